ascii_number_parser: RTL and testbench
======================================

// Module: ascii_number_parser
//
// PURPOSE
//   Downstream consumer of the RS-232 receiver in the root calculator.
//   - Turns the stream of received ASCII bytes into an unsigned binary
//     operand for the root-computation core.
//   - Accumulates decimal digits until a line terminator arrives, then
//     emits the value with a one-cycle valid pulse.
//   - Flags bad lines: overflow, illegal characters, receiver framing errors.
//
// PARAMETERS
//   WIDTH       16   width of the result; max value is 2^WIDTH-1
//   MAX_DIGITS  5    max decimal digits per line; must be >= digits in 2^WIDTH-1
//
// PORTS
//   clk          in   1      system clock
//   rst          in   1      asynchronous, active-high reset
//   rx_data      in   8      byte from receiver; stable while rx_ready is high
//   rx_ready     in   1      receiver byte-valid level, held high for many cycles
//   rx_error     in   1      receiver framing/start error level
//   value        out  WIDTH  last successfully parsed operand
//   value_valid  out  1      1-cycle pulse: value updated
//   parse_error  out  1      1-cycle pulse: a bad line was terminated
//   busy         out  1      high while a line is partially received (digit_cnt>0 or BAD)
//
// BEHAVIOUR
//   Reset (async):
//     - value=0, value_valid=0, parse_error=0, busy=0.
//     - acc=0, digit_cnt=0, state=IDLE.
//     - Edge-detect registers cleared.
//   Byte acceptance:
//     - A byte is taken only on a rising edge of rx_ready (registered previous
//       sample); the long high level yields exactly one byte.
//     - A rising edge of rx_error marks the current line BAD.
//     - If rx_ready and rx_error edges fall in the same cycle, the error wins
//       and the byte is discarded.
//   States:
//     - IDLE  -> ACCUM on a digit.
//     - ACCUM -> IDLE on a terminator.
//     - ACCUM -> BAD on an error.
//     - BAD   -> IDLE on a terminator.
//     - An error event in IDLE also moves to BAD.
//   Digit '0'..'9' (0x30..0x39), d = byte-0x30:
//     - nxt = acc*10 + d, computed as (acc<<3)+(acc<<1)+d in WIDTH+4 bits.
//     - If nxt > 2^WIDTH-1, or digit_cnt == MAX_DIGITS: go to BAD.
//     - Otherwise acc <= nxt and digit_cnt++.
//   Terminator CR (0x0D) or LF (0x0A):
//     - In ACCUM: value <= acc and value_valid=1 in the cycle after the
//       accepting edge; then clear acc/digit_cnt.
//     - In BAD: parse_error=1 for one cycle, then clear.
//     - In IDLE: ignored (empty line; covers CR LF pairs).
//   Any other byte in IDLE/ACCUM: go to BAD.
//   In BAD, all bytes except terminators are discarded.
//   value holds between pulses; value_valid and parse_error are never high
//   together. Leading zeros are allowed and count toward MAX_DIGITS.
//   Latency: 1 clk from rx_ready rising edge to output pulse.
//
// CONFIGURATION
//   ASCII_PARSER_ESC_EN defined:
//     - ESC (0x1B) in any state aborts the line.
//     - Clears acc/digit_cnt, returns to IDLE, no pulse on any output.
//   ASCII_PARSER_ESC_EN undefined:
//     - ESC is an ordinary illegal character (line goes BAD).
//
// TESTING
//   1. "123\r" -> one value_valid pulse, value=123, parse_error never high.
//   2. "65535\r" -> value=65535.
//      "65536\r" -> parse_error pulse, value stays 65535.
//   3. "\r\n\r\n" with no digits -> no pulses.
//      "7\r\n" -> exactly one pulse, value=7.
//   4. "12a4\r" -> parse_error pulse.
//      Following "42\r" -> value=42 (recovery).
//   5. "99" + rx_error edge coincident with '9' rx_ready edge + "\r" ->
//      parse_error pulse, no value_valid.
//      rst asserted mid-line "55" -> outputs zero at once; "8\r" -> value=8.
//   6. rx_ready held high 2604 cycles per byte for "31\r" -> single pulse,
//      value=31.
//      With ASCII_PARSER_ESC_EN: "12<ESC>9\r" -> value=9, no parse_error.

Source files
------------

// File: rtl/ascii_number_parser.sv
// Converts a stream of received ASCII decimal digits into an unsigned operand, one line at a time.
// Optional feature: define ASCII_PARSER_ESC_EN so that ESC aborts the current line silently.
module ascii_number_parser #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    input  logic             rx_error,
    output logic [WIDTH-1:0] value,
    output logic             value_valid,
    output logic             parse_error,
    output logic             busy
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

    typedef enum logic [1:0] {IDLE, ACCUM, BAD} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n, value_n;
    logic [CW-1:0]    digit_cnt, cnt_n;
    logic             vv_n, pe_n;
    logic             rdy_q, err_q;
    logic             rdy_edge, err_edge;
    logic             is_digit, is_term, is_esc;
    logic [WIDTH+3:0] nxt;

    // The receiver holds its level signals for many cycles; only rising edges count.
    assign rdy_edge = rx_ready & ~rdy_q;
    assign err_edge = rx_error & ~err_q;
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
`ifdef ASCII_PARSER_ESC_EN
    assign is_esc   = (rx_data == 8'h1B);
`else
    assign is_esc   = 1'b0;
`endif
    assign busy     = (digit_cnt != '0) || (state == BAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            digit_cnt   <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            parse_error <= 1'b0;
            rdy_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_n;
            acc         <= acc_n;
            digit_cnt   <= cnt_n;
            value       <= value_n;
            value_valid <= vv_n;
            parse_error <= pe_n;
            rdy_q       <= rx_ready;
            err_q       <= rx_error;
        end
    end

    // acc*10 + d in four extra bits so an overflow past 2^WIDTH-1 stays visible.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = digit_cnt;
        value_n = value;
        vv_n    = 1'b0;
        pe_n    = 1'b0;
        nxt     = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                + {{WIDTH{1'b0}}, rx_data[3:0]};

        if (err_edge) begin
            state_n = BAD;
        end else if (rdy_edge) begin
            if (is_esc) begin
                state_n = IDLE;
                acc_n   = '0;
                cnt_n   = '0;
            end else if (is_term) begin
                if (state == ACCUM) begin
                    value_n = acc;
                    vv_n    = 1'b1;
                end else if (state == BAD) begin
                    pe_n = 1'b1;
                end
                state_n = IDLE;
                acc_n   = '0;
                cnt_n   = '0;
            end else if (state != BAD) begin
                if (is_digit && (nxt[WIDTH+3:WIDTH] == 4'b0000) && (digit_cnt != MAX_CNT)) begin
                    acc_n   = nxt[WIDTH-1:0];
                    cnt_n   = digit_cnt + 1'b1;
                    state_n = ACCUM;
                end else begin
                    state_n = BAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_ascii_number_parser.sv
// Directed self-checking bench for ascii_number_parser; each task checks one scenario.
// Define ASCII_PARSER_ESC_EN for both bench and RTL to exercise the ESC abort path.
module tb_ascii_number_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic        rx_error = 1'b0;
    logic [15:0] value;
    logic        value_valid;
    logic        parse_error;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int vv_cnt = 0;
    int pe_cnt = 0;
    int both_cnt = 0;
    int vv0, pe0;
    logic first_vv, first_pe;

    ascii_number_parser #(.WIDTH(16), .MAX_DIGITS(5)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_error(rx_error), .value(value), .value_valid(value_valid),
        .parse_error(parse_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (value_valid) vv_cnt++;
            if (parse_error) pe_cnt++;
            if (value_valid && parse_error) both_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold, input logic with_err);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        if (with_err) rx_error = 1'b1;
        @(negedge clk);
        first_vv = value_valid;
        first_pe = parse_error;
        repeat (hold - 1) @(negedge clk);
        rx_ready = 1'b0;
        rx_error = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int hold);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], hold, 1'b0);
    endtask

    task automatic snap();
        vv0 = vv_cnt;
        pe0 = pe_cnt;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_value", 32'(value), 0);
        check("reset_vv", 32'(value_valid), 0);
        check("reset_pe", 32'(parse_error), 0);
        check("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        snap();
        send_str("123", 4);
        check("basic_busy", 32'(busy), 1);
        send_byte(8'h0D, 4, 1'b0);
        check("basic_latency_vv", 32'(first_vv), 1);
        check("basic_value", 32'(value), 123);
        check("basic_vv_count", 32'(vv_cnt - vv0), 1);
        check("basic_pe_count", 32'(pe_cnt - pe0), 0);
        check("basic_busy_after", 32'(busy), 0);
    endtask

    task automatic test_boundary();
        snap();
        send_str("65535", 3);
        send_byte(8'h0D, 3, 1'b0);
        check("max_value", 32'(value), 65535);
        check("max_vv_count", 32'(vv_cnt - vv0), 1);
        snap();
        send_str("65536", 3);
        send_byte(8'h0D, 3, 1'b0);
        check("ovf_pe_count", 32'(pe_cnt - pe0), 1);
        check("ovf_vv_count", 32'(vv_cnt - vv0), 0);
        check("ovf_value_hold", 32'(value), 65535);
        snap();
        send_str("000001", 3);
        send_byte(8'h0D, 3, 1'b0);
        check("maxdigits_pe_count", 32'(pe_cnt - pe0), 1);
        check("maxdigits_vv_count", 32'(vv_cnt - vv0), 0);
    endtask

    task automatic test_empty_lines();
        snap();
        send_byte(8'h0D, 3, 1'b0);
        send_byte(8'h0A, 3, 1'b0);
        send_byte(8'h0D, 3, 1'b0);
        send_byte(8'h0A, 3, 1'b0);
        check("empty_vv_count", 32'(vv_cnt - vv0), 0);
        check("empty_pe_count", 32'(pe_cnt - pe0), 0);
        check("empty_busy", 32'(busy), 0);
        snap();
        send_str("7", 3);
        send_byte(8'h0D, 3, 1'b0);
        send_byte(8'h0A, 3, 1'b0);
        check("crlf_vv_count", 32'(vv_cnt - vv0), 1);
        check("crlf_value", 32'(value), 7);
    endtask

    task automatic test_illegal();
        snap();
        send_str("12a4", 3);
        check("illegal_busy", 32'(busy), 1);
        send_byte(8'h0D, 3, 1'b0);
        check("illegal_latency_pe", 32'(first_pe), 1);
        check("illegal_pe_count", 32'(pe_cnt - pe0), 1);
        check("illegal_vv_count", 32'(vv_cnt - vv0), 0);
        check("illegal_value_hold", 32'(value), 7);
        send_str("42", 3);
        send_byte(8'h0D, 3, 1'b0);
        check("recover_value", 32'(value), 42);
    endtask

    task automatic test_rx_error();
        snap();
        send_byte("9", 3, 1'b0);
        send_byte("9", 3, 1'b1);
        send_byte(8'h0D, 3, 1'b0);
        check("rxerr_pe_count", 32'(pe_cnt - pe0), 1);
        check("rxerr_vv_count", 32'(vv_cnt - vv0), 0);
        check("rxerr_value_hold", 32'(value), 42);
    endtask

    task automatic test_reset_midline();
        send_str("55", 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_value", 32'(value), 0);
        check("midrst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        snap();
        send_str("8", 3);
        send_byte(8'h0D, 3, 1'b0);
        check("midrst_new_value", 32'(value), 8);
        check("midrst_vv_count", 32'(vv_cnt - vv0), 1);
    endtask

    task automatic test_long_hold();
        snap();
        send_str("31", 2604);
        send_byte(8'h0D, 2604, 1'b0);
        check("hold_vv_count", 32'(vv_cnt - vv0), 1);
        check("hold_value", 32'(value), 31);
    endtask

    task automatic test_esc();
        snap();
        send_str("12", 3);
        send_byte(8'h1B, 3, 1'b0);
        send_str("9", 3);
        send_byte(8'h0D, 3, 1'b0);
`ifdef ASCII_PARSER_ESC_EN
        check("esc_value", 32'(value), 9);
        check("esc_pe_count", 32'(pe_cnt - pe0), 0);
        check("esc_vv_count", 32'(vv_cnt - vv0), 1);
`else
        check("esc_value_hold", 32'(value), 31);
        check("esc_pe_count", 32'(pe_cnt - pe0), 1);
        check("esc_vv_count", 32'(vv_cnt - vv0), 0);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_empty_lines();
        test_illegal();
        test_rx_error();
        test_reset_midline();
        test_long_hold();
        test_esc();
        check("pulses_exclusive", 32'(both_cnt), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
